// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths and FSM state type for the VGA draw arbiter
// Contents:
//   X_W, Y_W, COLOUR_W : adapter coordinate and colour widths
//   arb_state_t        : arbiter FSM states (IDLE, GRANT, BUSY, RELEASE)
package vga_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req   in  N      request vector
//   ptr   in  IW     last winner; the scan starts at ptr+1 and wraps modulo N
//   valid out 1      any request set
//   index out IW     first set request found by the scan
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scan from the farthest offset down to ptr+1 so the nearest request
  // after ptr is written last and wins.
  always_comb begin
    int j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// rtl/vga_draw_arbiter.sv - round-robin sharing of the VGA adapter write port
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   req                   per-client draw request (level)
//   client_start          one-cycle start pulse to the granted client
//   client_done           per-client done pulse
//   client_x/y/colour     packed per-client pixel fields, client i at slot i
//   client_write          per-client write strobe
//   vga_x/y/colour/write  registered pixel write to the adapter
//   busy                  high in GRANT and BUSY
//   grant_id              current or last grantee
//   timeout_err           one-cycle pulse when the watchdog releases a grant
module vga_draw_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        client_start,
  input  logic [NUM_REQ-1:0]        client_done,
  input  logic [NUM_REQ*X_W-1:0]    client_x,
  input  logic [NUM_REQ*Y_W-1:0]    client_y,
  input  logic [NUM_REQ*COLOUR_W-1:0] client_colour,
  input  logic [NUM_REQ-1:0]        client_write,
  output logic [X_W-1:0]            vga_x,
  output logic [Y_W-1:0]            vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_write,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gid;
  logic [CW-1:0] cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign grant_id = 3'(gid);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= IW'(NUM_REQ - 1);
      gid          <= '0;
      cnt          <= '0;
      client_start <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= '0;
      vga_write    <= 1'b0;
    end else begin
      client_start <= '0;
      timeout_err  <= 1'b0;

      // Pixel fields always follow the grantee; only the write strobe is gated,
      // so coordinates and write stay aligned with one cycle of latency.
      vga_x      <= client_x[gid*X_W +: X_W];
      vga_y      <= client_y[gid*Y_W +: Y_W];
      vga_colour <= client_colour[gid*COLOUR_W +: COLOUR_W];
      vga_write  <= ((state == GRANT) || (state == BUSY)) && client_write[gid];

      case (state)
        IDLE: begin
          if (pick_valid) begin
            gid          <= pick_idx;
            client_start <= NUM_REQ'(1) << pick_idx;
            busy         <= 1'b1;
            state        <= GRANT;
          end
        end
        GRANT: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (client_done[gid]) begin
            busy  <= 1'b0;
            state <= RELEASE;
          end else if (WDOG_EN && (cnt == CNT_LAST)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          // Releasing client goes to the back of the round-robin order.
          ptr   <= gid;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb/tb_vga_draw_arbiter.sv - directed self-checking bench for vga_draw_arbiter and rr_pick
module tb_vga_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  client_start;
  logic [3:0]  client_done;
  logic [31:0] client_x;
  logic [27:0] client_y;
  logic [71:0] client_colour;
  logic [3:0]  client_write;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic        vga_write;
  logic        busy;
  logic [2:0]  grant_id;
  logic        timeout_err;

  logic [3:0]  pk_req;
  logic [1:0]  pk_ptr;
  logic        pk_valid;
  logic [1:0]  pk_index;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  vga_draw_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .client_start  (client_start),
    .client_done   (client_done),
    .client_x      (client_x),
    .client_y      (client_y),
    .client_colour (client_colour),
    .client_write  (client_write),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_write     (vga_write),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_err   (timeout_err)
  );

  rr_pick #(.N(4)) u_pick (
    .req   (pk_req),
    .ptr   (pk_ptr),
    .valid (pk_valid),
    .index (pk_index)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pix(input int i, input logic [7:0] x, input logic [6:0] y,
                           input logic [17:0] c, input logic w);
    client_x[i*8 +: 8]       = x;
    client_y[i*7 +: 7]       = y;
    client_colour[i*18 +: 18] = c;
    client_write[i]          = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Ticks until a start pulse is visible; bounded.
  task automatic wait_start(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (client_start != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int exp_order [5];
    bit early;
    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; client_done = '0; client_write = '0;
    client_x = '0; client_y = '0; client_colour = '0;
    pk_req = '0; pk_ptr = '0;

    // rr_pick unit vectors
    #1;
    check("pick_none_valid", 32'(pk_valid), 32'd0);
    pk_req = 4'b1111; pk_ptr = 2'd3; #1;
    check("pick_all_p3", 32'(pk_index), 32'd0);
    pk_ptr = 2'd0; #1;
    check("pick_all_p0", 32'(pk_index), 32'd1);
    pk_req = 4'b0001; pk_ptr = 2'd0; #1;
    check("pick_wrap_self", 32'(pk_index), 32'd0);
    pk_req = 4'b1010; pk_ptr = 2'd1; #1;
    check("pick_1010_p1", 32'(pk_index), 32'd3);
    pk_ptr = 2'd3; #1;
    check("pick_1010_p3", 32'(pk_index), 32'd1);
    check("pick_valid", 32'(pk_valid), 32'd1);

    // Reset state
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_start", 32'(client_start), 32'd0);
    check("rst_vga_write", 32'(vga_write), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);

    // Test 1: single client, one pixel
    reset = 1'b0; req = 4'b0001;                       // cycle 0
    tick();                                            // cycle 1
    check("t1_start", 32'(client_start), 32'b0001);
    check("t1_busy_grant", 32'(busy), 32'd1);
    tick();                                            // cycle 2
    check("t1_start_pulse", 32'(client_start), 32'd0);
    tick();                                            // cycle 3
    drive_pix(0, 8'd80, 7'd60, 18'h3FFFF, 1'b1);
    tick();                                            // cycle 4
    check("t1_vga_x", 32'(vga_x), 32'd80);
    check("t1_vga_y", 32'(vga_y), 32'd60);
    check("t1_vga_colour", 32'(vga_colour), 32'h3FFFF);
    check("t1_vga_write", 32'(vga_write), 32'd1);
    client_write = '0;
    tick();                                            // cycle 5
    check("t1_write_off", 32'(vga_write), 32'd0);
    client_done = 4'b0001; req = '0;
    tick();                                            // cycle 6
    client_done = '0;
    tick();                                            // cycle 7
    check("t1_busy_end", 32'(busy), 32'd0);

    // Test 2: all request, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) drive_pix(i, 8'(20 + i), 7'd1, 18'd0, 1'b1);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_start($sformatf("t2_start_seen_%0d", g));
      check($sformatf("t2_grant_id_%0d", g), 32'(grant_id), 32'(exp_order[g]));
      check($sformatf("t2_start_%0d", g), 32'(client_start), 32'(4'b0001 << exp_order[g]));
      tick();                                          // s+1
      tick();                                          // s+2
      check($sformatf("t2_vga_x_%0d", g), 32'(vga_x), 32'(20 + exp_order[g]));
      check($sformatf("t2_vga_write_%0d", g), 32'(vga_write), 32'd1);
      tick();                                          // s+3
      client_done[exp_order[g]] = 1'b1;
      tick();                                          // s+4
      client_done = '0;
      check($sformatf("t2_done_write_%0d", g), 32'(vga_write), 32'd1);
      tick();                                          // s+5
      check($sformatf("t2_idle_write_%0d", g), 32'(vga_write), 32'd0);
      check($sformatf("t2_idle_busy_%0d", g), 32'(busy), 32'd0);
    end
    req = '0; client_write = '0;

    // Test 3: non-granted client writes and done are ignored
    do_reset();
    drive_pix(2, 8'd10, 7'd2, 18'h00ABC, 1'b1);
    req = 4'b0010;
    wait_start("t3_start_seen");
    check("t3_grant_id", 32'(grant_id), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();                                          // s+k
      if (k > 1) begin
        check($sformatf("t3_vga_x_%0d", k), 32'(vga_x), 32'(40 + k - 1));
        check($sformatf("t3_vga_write_%0d", k), 32'(vga_write), 32'd1);
      end
      if (k == 3) check("t3_foreign_done", 32'(busy), 32'd1);
      drive_pix(1, 8'(40 + k), 7'd3, 18'd5, 1'b1);
      client_done = '0;
      if (k == 2) client_done[2] = 1'b1;
      if (k == 4) client_done[1] = 1'b1;
    end
    tick();                                            // s+5
    client_done = '0; req = '0; client_write[1] = 1'b0;
    check("t3_last_x", 32'(vga_x), 32'd44);
    check("t3_last_write", 32'(vga_write), 32'd1);
    check("t3_busy_end", 32'(busy), 32'd0);
    tick();                                            // s+6
    check("t3_write_off", 32'(vga_write), 32'd0);
    client_write = '0;

    // Test 4: watchdog
    do_reset();
    req = 4'b0011;
    wait_start("t4_start_seen");
    check("t4_grant_id", 32'(grant_id), 32'd0);
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();                                          // s+k
      if (timeout_err) early = 1'b1;
    end
    check("t4_no_early_timeout", 32'(early), 32'd0);
    tick();                                            // s+17
    check("t4_timeout_pulse", 32'(timeout_err), 32'd1);
    req = 4'b0010;
    tick();                                            // s+18
    check("t4_timeout_one_cycle", 32'(timeout_err), 32'd0);
    check("t4_no_start_yet", 32'(client_start), 32'd0);
    tick();                                            // s+19
    check("t4_next_start", 32'(client_start), 32'b0010);
    check("t4_next_grant", 32'(grant_id), 32'd1);
    tick();
    client_done = 4'b0010; req = '0;
    tick();
    client_done = '0;
    tick(); tick();

    // Test 5: reset in BUSY, then fresh pointer
    req = 4'b1000;
    wait_start("t5_start_seen");
    check("t5_grant_id", 32'(grant_id), 32'd3);
    tick();                                            // s+1
    tick();                                            // s+2
    drive_pix(3, 8'd5, 7'd5, 18'd5, 1'b1);
    tick();                                            // s+3
    check("t5_write_before_rst", 32'(vga_write), 32'd1);
    reset = 1'b1;
    tick();                                            // s+4
    check("t5_rst_write", 32'(vga_write), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_grant", 32'(grant_id), 32'd0);
    reset = 1'b0; client_write = '0; req = 4'b0100;
    wait_start("t5_restart_seen");
    check("t5_regrant", 32'(grant_id), 32'd2);
    check("t5_regrant_start", 32'(client_start), 32'b0100);

    // Test 6: last write on the done cycle
    tick();                                            // s+1
    tick();                                            // s+2
    drive_pix(2, 8'd159, 7'd119, 18'h12345, 1'b1);
    client_done = 4'b0100; req = '0;
    tick();                                            // s+3
    client_done = '0; client_write = '0;
    check("t6_x", 32'(vga_x), 32'd159);
    check("t6_y", 32'(vga_y), 32'd119);
    check("t6_write", 32'(vga_write), 32'd1);
    tick();                                            // s+4
    check("t6_write_off", 32'(vga_write), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter write port between NUM_REQ drawing engines, e.g. wall column renderer, crosshair and HUD.
- Each engine uses the start/done handshake and drives its own vga_x/vga_y/vga_colour/vga_write.
- The arbiter picks one requester round-robin, pulses its start, and forwards only that engine's pixel writes to the adapter until it reports done.
- A watchdog force-releases a client that never finishes.

Parameters:
- NUM_REQ, 4, number of drawing clients (2..8).
- TIMEOUT, 4096, maximum cycles a grant is held before forced release; 0 disables the watchdog.

Ports:
- clock  in  1  global clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-client request to draw; level, held until the client's done.
- client_start  out  NUM_REQ  one-cycle start pulse to the granted client.
- client_done  in  NUM_REQ  per-client done pulse.
- client_x  in  NUM_REQ*8  packed x coordinates; client i occupies [8i+7:8i].
- client_y  in  NUM_REQ*7  packed y coordinates.
- client_colour  in  NUM_REQ*18  packed colours.
- client_write  in  NUM_REQ  per-client write strobe.
- vga_x  out  8  to adapter, registered.
- vga_y  out  7  to adapter, registered.
- vga_colour  out  18  to adapter, registered.
- vga_write  out  1  to adapter, registered.
- busy  out  1  high while any grant is active (GRANT or BUSY state).
- grant_id  out  3  index of the current or last grantee.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values: state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so client 0 wins first; timeout counter 0.
- States and transitions:
  - IDLE: if |req, pick the winner = first set req scanning from ptr+1 with wrap modulo NUM_REQ. Latch it into grant_id and go to GRANT.
  - GRANT (1 cycle): client_start[grant_id]=1, all other start bits 0. Clear the counter. Go to BUSY.
  - BUSY: forward the granted client's signals. Counter increments each cycle.
    - client_done[grant_id] goes to RELEASE.
    - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1, pulse timeout_err and go to RELEASE.
  - RELEASE (1 cycle): ptr <= grant_id; vga_write forced 0. Go to IDLE.
- Latency:
  - req seen high in IDLE at cycle t gives start at t+1; BUSY begins at t+2.
  - Minimum grant-to-grant turnaround is 4 cycles.
- Output path:
  - Every cycle, vga_x/y/colour <= fields of client grant_id.
  - vga_write <= client_write[grant_id] when state is GRANT or BUSY, else 0.
  - This gives exactly one cycle of latency; coordinates and write stay aligned.
- A write asserted in the same cycle as done is forwarded; the write registered on the done cycle appears on the next cycle.
- Writes and done pulses from non-granted clients are ignored and never reach the adapter.
- A grantee dropping req mid-grant is ignored; the grant is held until done or timeout.
- Fairness: a client still requesting after release goes behind all other pending clients.
- Done pulse arriving in GRANT (a zero-length draw): not accepted; only done in BUSY counts. Clients must not assert done before the cycle after start.
- Reset mid-grant: immediate return to IDLE, start/write low next cycle, ptr reinitialised.
- Widths: the counter is clog2(TIMEOUT+1) bits and saturates, never wraps. grant_id is zero-extended into its 3 bits.

Decomposition:
- Package vga_pkg:
  - X_W=8, Y_W=7, COLOUR_W=18.
  - State localparams IDLE=0, GRANT=1, BUSY=2, RELEASE=3.
- Sub-module rr_pick: a combinational round-robin picker (req vector, ptr) -> (valid, index).
  - Instantiated once; unit-tested separately.

Test Plan:
- Reset, then req=4'b0001 at cycle 0 -> client_start=4'b0001 at cycle 1. Client then writes (x=80,y=60,colour=18'h3FFFF) at cycle 3 -> vga_x=80, vga_y=60, vga_write=1 at cycle 4; done at cycle 5 -> busy=0 at cycle 7.
- req=4'b1111 held, every client done 3 cycles after its start -> grant order 0,1,2,3,0, with no adapter write outside a grant.
- Client 1 granted, client 2 drives client_write=1 with x=10 throughout -> vga_write never shows x=10; only client 1 pixels appear.
- TIMEOUT=16, client 0 granted and never signals done -> timeout_err pulses exactly 16 cycles after BUSY entry; client 1 (pending) is started 2 cycles later.
- Reset asserted in BUSY with client_write=1 -> next cycle vga_write=0, busy=0, grant_id=0. A subsequent req=4'b0100 is granted to client 2.
- Last write on the same cycle as done (x=159,y=119) -> that pixel appears on vga_x/vga_y one cycle later with vga_write=1. The following cycle vga_write=0.
